// File: rtl/ai_stream_bridge.sv
// Camera-to-FINN stream bridge: pixel FIFO, result pairing, sync delay, error flags and frame counters.
// Optional AI_BYPASS_EN adds a bypass input that pairs pixels with a zero result without using the accelerator.
module ai_stream_bridge #(
  parameter int PIX_W      = 24,
  parameter int RES_W      = 768,
  parameter int FIFO_DEPTH = 64,
  parameter int SYNC_LAT   = 4,
  parameter int CNT_W      = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_vsync,
  input  logic             in_hsync,
  input  logic             in_den,
  input  logic [PIX_W-1:0] in_data,
  output logic [PIX_W-1:0] acc_s_tdata,
  output logic             acc_s_tvalid,
  input  logic             acc_s_tready,
  input  logic [RES_W-1:0] acc_m_tdata,
  input  logic             acc_m_tvalid,
  output logic             acc_m_tready,
  output logic             pair_valid,
  output logic [PIX_W-1:0] pair_pix,
  output logic [RES_W-1:0] pair_res,
  output logic             out_vsync,
  output logic             out_hsync,
`ifdef AI_BYPASS_EN
  input  logic             bypass,
`endif
  input  logic             clr_err,
  output logic             drop_err,
  output logic             unf_err,
  output logic [CNT_W-1:0] in_count,
  output logic [CNT_W-1:0] out_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic             vsync_q, hsync_q, den_q, vsync_qq;
  logic [PIX_W-1:0] data_q;
  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, occ;
  logic             fifo_full, fifo_empty;
  logic             byp, accept, pop, byp_pair, drop_now, unf_now, pair_now, frame_start;

`ifdef AI_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  // Full/empty come from pre-update occupancy, so a same-cycle pop never frees room for a push.
  assign occ        = wr_ptr - rd_ptr;
  assign fifo_full  = (occ == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (occ == '0);

  assign acc_s_tdata  = data_q;
  assign acc_s_tvalid = den_q & ~fifo_full & ~byp;
  assign acc_m_tready = 1'b1;

  assign accept      = acc_s_tvalid & acc_s_tready;
  assign pop         = acc_m_tvalid & ~fifo_empty;
  assign byp_pair    = byp & den_q & ~pop;
  assign drop_now    = (den_q & ~byp & ~accept) | (byp & den_q & pop);
  assign unf_now     = acc_m_tvalid & fifo_empty;
  assign pair_now    = pop | byp_pair;
  assign frame_start = vsync_q & ~vsync_qq;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q    <= 1'b0;
      hsync_q    <= 1'b0;
      den_q      <= 1'b0;
      data_q     <= '0;
      vsync_qq   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pair_valid <= 1'b0;
      pair_pix   <= '0;
      pair_res   <= '0;
      drop_err   <= 1'b0;
      unf_err    <= 1'b0;
      in_count   <= '0;
      out_count  <= '0;
    end else begin
      vsync_q  <= in_vsync;
      hsync_q  <= in_hsync;
      den_q    <= in_den;
      data_q   <= in_data;
      vsync_qq <= vsync_q;

      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;

      pair_valid <= pair_now;
      if (pop) begin
        pair_pix <= mem[rd_ptr[AW-1:0]];
        pair_res <= acc_m_tdata;
      end else if (byp_pair) begin
        pair_pix <= data_q;
        pair_res <= '0;
      end

      // A new error in the clearing cycle keeps the flag set.
      drop_err <= drop_now | (drop_err & ~clr_err);
      unf_err  <= unf_now  | (unf_err  & ~clr_err);

      if (frame_start)                       in_count <= CNT_W'(accept);
      else if (accept && (in_count != '1))   in_count <= in_count + 1'b1;

      if (frame_start)                       out_count <= CNT_W'(pair_now);
      else if (pair_now && (out_count != '1)) out_count <= out_count + 1'b1;
    end
  end

  generate
    if (SYNC_LAT == 0) begin : g_no_delay
      assign out_vsync = vsync_q;
      assign out_hsync = hsync_q;
    end else begin : g_delay
      logic [SYNC_LAT-1:0] vs_sr, hs_sr;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vs_sr <= '0;
          hs_sr <= '0;
        end else begin
          vs_sr <= SYNC_LAT'({vs_sr, vsync_q});
          hs_sr <= SYNC_LAT'({hs_sr, hsync_q});
        end
      end
      assign out_vsync = vs_sr[SYNC_LAT-1];
      assign out_hsync = hs_sr[SYNC_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_ai_stream_bridge.sv
// Directed self-checking bench for ai_stream_bridge (small FIFO, 32-bit results, 4-cycle extra sync delay).
module tb_ai_stream_bridge;
  localparam int PIX_W = 24, RES_W = 32, FIFO_DEPTH = 4, SYNC_LAT = 4, CNT_W = 22;

  logic clk = 0, reset_n = 0;
  logic in_vsync = 0, in_hsync = 0, in_den = 0;
  logic [PIX_W-1:0] in_data = '0;
  logic [PIX_W-1:0] acc_s_tdata;
  logic acc_s_tvalid, acc_s_tready = 1;
  logic [RES_W-1:0] acc_m_tdata = '0;
  logic acc_m_tvalid = 0, acc_m_tready;
  logic pair_valid;
  logic [PIX_W-1:0] pair_pix;
  logic [RES_W-1:0] pair_res;
  logic out_vsync, out_hsync, clr_err = 0, drop_err, unf_err;
  logic [CNT_W-1:0] in_count, out_count;
`ifdef AI_BYPASS_EN
  logic bypass = 0;
`endif

  int checks = 0, errors = 0;
  logic [PIX_W-1:0] pix_q [$];
  logic [RES_W-1:0] res_q [$];
  logic pv [5];
  logic [RES_W-1:0] pd [5];
  bit echo_en = 0;

  ai_stream_bridge #(.PIX_W(PIX_W), .RES_W(RES_W), .FIFO_DEPTH(FIFO_DEPTH),
                     .SYNC_LAT(SYNC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den), .in_data(in_data),
    .acc_s_tdata(acc_s_tdata), .acc_s_tvalid(acc_s_tvalid), .acc_s_tready(acc_s_tready),
    .acc_m_tdata(acc_m_tdata), .acc_m_tvalid(acc_m_tvalid), .acc_m_tready(acc_m_tready),
    .pair_valid(pair_valid), .pair_pix(pair_pix), .pair_res(pair_res),
    .out_vsync(out_vsync), .out_hsync(out_hsync),
`ifdef AI_BYPASS_EN
    .bypass(bypass),
`endif
    .clr_err(clr_err), .drop_err(drop_err), .unf_err(unf_err),
    .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample pairs just after the edge, then advance the echoing accelerator model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pair_valid === 1'b1) begin
      pix_q.push_back(pair_pix);
      res_q.push_back(pair_res);
    end
    if (echo_en) begin
      acc_m_tvalid = pv[4];
      acc_m_tdata  = pd[4];
      for (int i = 4; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = acc_s_tvalid & acc_s_tready;
      pd[0] = {8'hA5, acc_s_tdata};
    end
  endtask

  task automatic applyStimulus(input logic den, input logic [PIX_W-1:0] d);
    in_den  = den;
    in_data = d;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      pv[i] = 0;
      pd[i] = '0;
    end
    #12;
    checkOutput("rst_tready", acc_m_tready, 1);
    checkOutput("rst_tvalid", acc_s_tvalid, 0);
    checkOutput("rst_pair", pair_valid, 0);
    checkOutput("rst_flags", {drop_err, unf_err, out_vsync, out_hsync}, 0);
    checkOutput("rst_counts", {in_count, out_count}, 0);
    @(negedge clk);
    reset_n = 1;
    tick();

    // Streaming through an echoing accelerator, one pixel every other cycle.
    echo_en = 1;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, PIX_W'(i));
      applyStimulus(0, '0);
    end
    repeat (12) applyStimulus(0, '0);
    echo_en = 0;
    acc_m_tvalid = 0;
    checkOutput("t1_npairs", pix_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t1_pix%0d", i), pix_q[i], i + 1);
      checkOutput($sformatf("t1_res%0d", i), res_q[i], {8'hA5, 24'(i + 1)});
    end
    checkOutput("t1_in_count", in_count, 16);
    checkOutput("t1_out_count", out_count, 16);
    checkOutput("t1_flags", {drop_err, unf_err}, 0);
    pix_q.delete();
    res_q.delete();

    // Frame start clears the counters.
    in_vsync = 1;
    tick();
    in_vsync = 0;
    tick();
    tick();
    checkOutput("t4_counts_cleared", {in_count, out_count}, 0);

    // hsync pulse reappears 1+SYNC_LAT edges later for exactly one cycle.
    in_hsync = 1;
    tick();
    in_hsync = 0;
    for (int k = 2; k <= 7; k++) begin
      tick();
      checkOutput($sformatf("t4_hsync_k%0d", k), out_hsync, (k == 5));
    end

    // Overflow with results withheld.
    for (int i = 1; i <= 6; i++) applyStimulus(1, PIX_W'(24'h100 + i));
    applyStimulus(0, '0);
    applyStimulus(0, '0);
    checkOutput("t2_in_count", in_count, 4);
    checkOutput("t2_drop", drop_err, 1);
    checkOutput("t2_no_pairs", pix_q.size(), 0);
    for (int k = 0; k < 4; k++) begin
      acc_m_tvalid = 1;
      acc_m_tdata  = RES_W'(32'hB0 + k);
      tick();
    end
    acc_m_tvalid = 0;
    tick();
    checkOutput("t2_npairs", pix_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_pix%0d", k), pix_q[k], 24'h101 + k);
      checkOutput($sformatf("t2_res%0d", k), res_q[k], 32'hB0 + k);
    end
    checkOutput("t2_out_count", out_count, 4);
    checkOutput("t2_unf", unf_err, 0);
    pix_q.delete();
    res_q.delete();

    // Underflow and clear priority.
    clr_err = 1;
    tick();
    clr_err = 0;
    checkOutput("t3_drop_cleared", drop_err, 0);
    acc_m_tvalid = 1;
    tick();
    acc_m_tvalid = 0;
    checkOutput("t3_unf", unf_err, 1);
    checkOutput("t3_no_pair", pair_valid, 0);
    tick();
    clr_err = 1;
    acc_m_tvalid = 1;
    tick();
    clr_err = 0;
    acc_m_tvalid = 0;
    checkOutput("t3_unf_wins_clear", unf_err, 1);
    clr_err = 1;
    tick();
    clr_err = 0;
    checkOutput("t3_unf_cleared", unf_err, 0);

    // A push does not satisfy a result in the same cycle; it is poppable next cycle.
    applyStimulus(1, 24'h2AA);
    in_den = 0;
    acc_m_tvalid = 1;
    acc_m_tdata = 32'hC1;
    tick();
    acc_m_tvalid = 0;
    checkOutput("t3_push_unf", unf_err, 1);
    checkOutput("t3_push_no_pair", pair_valid, 0);
    acc_m_tvalid = 1;
    tick();
    acc_m_tvalid = 0;
    checkOutput("t3_late_pair", pair_valid, 1);
    checkOutput("t3_late_pix", pair_pix, 24'h2AA);
    checkOutput("t3_late_res", pair_res, 32'hC1);
    tick();
    clr_err = 1;
    tick();
    clr_err = 0;
    pix_q.delete();
    res_q.delete();

    // Push against a full FIFO while popping: push blocked, occupancy drops to FIFO_DEPTH-1.
    for (int i = 1; i <= 5; i++) applyStimulus(1, PIX_W'(24'h300 + i));
    in_den = 0;
    acc_m_tvalid = 1;
    acc_m_tdata = 32'hD0;
    tick();
    checkOutput("t5_drop", drop_err, 1);
    for (int k = 1; k <= 3; k++) begin
      acc_m_tdata = RES_W'(32'hD0 + k);
      tick();
    end
    acc_m_tvalid = 0;
    tick();
    checkOutput("t5_npairs", pix_q.size(), 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t5_pix%0d", k), pix_q[k], 24'h301 + k);
    checkOutput("t5_unf_clean", unf_err, 0);
    acc_m_tvalid = 1;
    tick();
    acc_m_tvalid = 0;
    checkOutput("t5_now_empty", unf_err, 1);
    checkOutput("t5_in_count", in_count, 9);
    checkOutput("t5_out_count", out_count, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
